seven_seg_scan_decoder: RTL
===========================

Name: seven_seg_scan_decoder

Overview:
- Inverse of the hex-to-seven-segment encoder.
- Samples a multiplexed, active-low 4-digit 7-segment bus (segments plus digit anodes), as driven to the board display.
- Recovers each digit's hex nibble and decimal point, and presents a complete frame to downstream logic over a valid/ready handshake.
- Used for loopback self-checking of the display path and for snooping externally driven displays.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits / anode lines.
- STABLE_CYCLES, 16: consecutive identical samples required before a digit is captured (min 2).
- CNT_W, 5: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  8  active-low segments; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- an_n  in  NUM_DIGITS  active-low digit enables; one-hot-low when valid.
- hex_out  out  4*NUM_DIGITS  decoded nibbles; digit i in [4i+3:4i].
- dp_out  out  NUM_DIGITS  decimal point per digit (1 = lit).
- err_out  out  NUM_DIGITS  digit i held an unrecognised pattern in this frame.
- frame_valid  out  1  frame available; held until accepted.
- frame_ready  in  1  consumer accepts the frame when high with frame_valid.
- overrun  out  1  sticky: a frame completed while the previous one was still pending.

Behaviour:
- Input sync: seg_n and an_n pass through 2-flop synchronisers; all logic uses synced values (2-cycle input latency).
- Inversion: seven = ~seg_n[6:0], dp = ~seg_n[7], sel = ~an_n.
- Decode table, seven to nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
- Any other pattern, including blank 00: nibble 0, err = 1.
- FSM states:
  - S_IDLE: sel not one-hot; counter cleared. Go to S_COUNT when sel is one-hot.
  - S_COUNT: counter increments while {sel, seg} equal the previous sample. Any change restarts the count; if sel is no longer one-hot, go to S_IDLE. When count reaches STABLE_CYCLES-1, capture into the shadow digit register and go to S_HELD.
  - S_HELD: wait until {sel, seg} changes, then go to S_COUNT (or S_IDLE if sel is not one-hot). No recapture while held.
- Capture: writes shadow nibble/dp/err for the selected digit and sets seen[i].
- Frame completion: when seen is all-ones, on the next cycle:
  - shadow copies to the output registers;
  - frame_valid is set;
  - seen is cleared.
- Handshake: frame_valid stays high and the outputs stay stable until a cycle with frame_ready = 1.
  - frame_valid drops on the following edge unless a new frame completes in that same cycle, in which case the new frame loads and frame_valid stays high.
- Frame completes while frame_valid = 1 and frame_ready = 0: outputs are overwritten with the newer frame and overrun is set. overrun clears only on reset.
- Re-capture of a digit already seen in the current frame overwrites its shadow entry (last value wins).
- Multiple anodes active or none: treated as no selection; no capture.
- Reset (async, any time, including mid-count or with a frame pending):
  - hex_out = 0, dp_out = 0, err_out = 0, frame_valid = 0, overrun = 0;
  - shadow, seen, counter and synchronisers are cleared; state = S_IDLE.
- Minimum latency from a stable input to capture: 2 (sync) + STABLE_CYCLES cycles.

Optional Feature:
- Macro SEG_ALT_GLYPH_EN.
- Defined: alternate glyphs also decode without error: 27→7 (with segment f) and 67→9 (no bottom segment).
- Undefined: these patterns set err and decode to 0.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry glyph localparams;
  - the alternate glyph constants;
  - the FSM state typedef/encodings;
  - SEG_DP_BIT = 7.
- One sub-module, seven_seg_glyph_decode: combinational 7-bit pattern → {err, nibble}, including the SEG_ALT_GLYPH_EN handling. It is reusable by other display checkers.

Test Plan:
- Scan "1234", each digit held 20 cycles, dp on digit 2, frame_ready = 1: frame_valid pulses 1 cycle, hex_out = 16'h1234 (digit 3 in the top nibble), dp_out = 4'b0100, err_out = 0.
- Digit 0 glitches to 0x7F for 5 cycles, then 0x06 for 20 cycles: captured value is 1, never 8.
- Digit 1 drives 0x00, others valid: err_out = 4'b0010, hex_out nibble 1 = 0.
- frame_ready = 0 across two full frames "ABCD" then "0F0F": frame_valid stays high, hex_out = 16'h0F0F, overrun = 1; raising frame_ready drops frame_valid next cycle.
- Assert rst_n = 0 mid-count with a frame pending: all outputs are 0 immediately (asynchronous); after release, no frame is produced until all 4 digits are recaptured.
- Pattern 0x27 on digit 0: with SEG_ALT_GLYPH_EN, nibble = 7 and err = 0; without it, nibble = 0 and err = 1.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan decoder family:
// glyph patterns (active-high, bit order g,f,e,d,c,b,a), alternate
// glyphs, the scan FSM state type and the decimal-point bit position.
package seven_seg_pkg;

    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Alternate renderings some drivers use: 7 with the f segment lit,
    // 9 without the bottom (d) segment.
    localparam logic [6:0] GLYPH_ALT_7 = 7'h27;
    localparam logic [6:0] GLYPH_ALT_9 = 7'h67;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Unrecognised patterns (including blank) decode to 0 with err set.
// Build option: define SEG_ALT_GLYPH_EN to also accept the alternate
// 7 (0x27) and 9 (0x67) glyphs without error.
module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seven,
    output logic [3:0] nibble,
    output logic       err
);

    // Table lookup of the active-high segment pattern
    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (seven)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
`ifdef SEG_ALT_GLYPH_EN
            GLYPH_ALT_7: nibble = 4'h7;
            GLYPH_ALT_9: nibble = 4'h9;
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment bus, captures each digit
// once it has been stable long enough, and hands complete frames to the
// consumer over a valid/ready handshake. Unconsumed frames are replaced
// by newer ones and flagged through the sticky overrun output.
// Build option: SEG_ALT_GLYPH_EN (see seven_seg_glyph_decode).
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    logic [7:0]              seg_meta;
    logic [7:0]              seg_sync;
    logic [NUM_DIGITS-1:0]   an_meta;
    logic [NUM_DIGITS-1:0]   an_sync;
    logic [7:0]              seg_prev;
    logic [NUM_DIGITS-1:0]   an_prev;

    logic [NUM_DIGITS-1:0]   sel;
    logic [6:0]              seven;
    logic                    dp;
    logic                    sel_one_hot;
    logic                    sample_changed;

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_plus;
    logic                    cnt_done;
    logic                    cnt_clear;
    logic                    cnt_inc;
    logic                    capture;

    scan_state_t             state;
    scan_state_t             state_next;

    logic [3:0]              dec_nibble;
    logic                    dec_err;

    logic [4*NUM_DIGITS-1:0] hex_shadow;
    logic [NUM_DIGITS-1:0]   dp_shadow;
    logic [NUM_DIGITS-1:0]   err_shadow;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    frame_done;

    // Two-flop synchronisers on the raw display bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta <= '0;
            seg_sync <= '0;
            an_meta  <= '0;
            an_sync  <= '0;
        end else begin
            seg_meta <= seg_n;
            seg_sync <= seg_meta;
            an_meta  <= an_n;
            an_sync  <= an_meta;
        end
    end

    assign sel            = ~an_sync;
    assign seven          = ~seg_sync[SEG_DP_BIT-1:0];
    assign dp             = ~seg_sync[SEG_DP_BIT];
    assign sel_one_hot    = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    assign sample_changed = ({an_sync, seg_sync} != {an_prev, seg_prev});
    assign cnt_plus       = cnt + CNT_W'(1);
    assign cnt_done       = (cnt_plus == CNT_W'(STABLE_CYCLES - 1));
    assign frame_done     = &seen;

    seven_seg_glyph_decode u_glyph_decode (
        .seven  (seven),
        .nibble (dec_nibble),
        .err    (dec_err)
    );

    // Remember last cycle's synchronised sample for stability detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_prev <= '0;
            an_prev  <= '0;
        end else begin
            seg_prev <= seg_sync;
            an_prev  <= an_sync;
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Scan FSM next-state: wait for a single digit, count its stability, hold after capture
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (sel_one_hot) begin
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!sel_one_hot) begin
                    state_next = S_IDLE;
                end else if (!sample_changed && cnt_done) begin
                    state_next = S_HELD;
                end
            end
            S_HELD: begin
                if (sample_changed) begin
                    state_next = sel_one_hot ? S_COUNT : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Scan FSM outputs: counter control and the capture strobe
    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: cnt_clear = 1'b1;
            S_COUNT: begin
                if (!sel_one_hot || sample_changed) begin
                    cnt_clear = 1'b1;
                end else if (cnt_done) begin
                    capture   = 1'b1;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_HELD: begin
                if (sample_changed) begin
                    cnt_clear = 1'b1;
                end
            end
            default: cnt_clear = 1'b1;
        endcase
    end

    // Stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt_plus;
        end
    end

    // Shadow frame: latest captured value per digit plus which digits have been seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_shadow <= '0;
            dp_shadow  <= '0;
            err_shadow <= '0;
            seen       <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && sel[i]) begin
                    hex_shadow[4*i +: 4] <= dec_nibble;
                    dp_shadow[i]         <= dp;
                    err_shadow[i]        <= dec_err;
                end
            end
            if (frame_done) begin
                seen <= capture ? sel : '0;
            end else if (capture) begin
                seen <= seen | sel;
            end
        end
    end

    // Output frame register and valid/ready handshake with sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out     <= '0;
            dp_out      <= '0;
            err_out     <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (frame_done) begin
            hex_out     <= hex_shadow;
            dp_out      <= dp_shadow;
            err_out     <= err_shadow;
            frame_valid <= 1'b1;
            if (frame_valid && !frame_ready) begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule
